// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants for the 4-digit 7-segment scan controller.
//   - active-low glyphs for 0..9, dash and blank ({dp,g,f,e,d,c,b,a})
//   - active-low digit-enable codes, bit3 = leftmost digit
//   - digit-select state type and a BCD-digit-to-glyph helper
package fnd_pkg;

   localparam logic [7:0] FONT_0     = 8'hC0;
   localparam logic [7:0] FONT_1     = 8'hF9;
   localparam logic [7:0] FONT_2     = 8'hA4;
   localparam logic [7:0] FONT_3     = 8'hB0;
   localparam logic [7:0] FONT_4     = 8'h99;
   localparam logic [7:0] FONT_5     = 8'h92;
   localparam logic [7:0] FONT_6     = 8'h82;
   localparam logic [7:0] FONT_7     = 8'hF8;
   localparam logic [7:0] FONT_8     = 8'h80;
   localparam logic [7:0] FONT_9     = 8'h90;
   localparam logic [7:0] FONT_DASH  = 8'hBF;
   localparam logic [7:0] FONT_BLANK = 8'hFF;

   localparam logic [3:0] COM_OFF = 4'b1111;
   localparam logic [3:0] COM_D0  = 4'b1110;
   localparam logic [3:0] COM_D1  = 4'b1101;
   localparam logic [3:0] COM_D2  = 4'b1011;
   localparam logic [3:0] COM_D3  = 4'b0111;

   localparam int unsigned DP_BIT = 7;

   typedef enum logic [1:0] {
      SEL_D0 = 2'd0,
      SEL_D1 = 2'd1,
      SEL_D2 = 2'd2,
      SEL_D3 = 2'd3
   } sel_e;

   function automatic logic [7:0] font_of(input logic [3:0] d);
      logic [7:0] f;
      case (d)
         4'd0:    f = FONT_0;
         4'd1:    f = FONT_1;
         4'd2:    f = FONT_2;
         4'd3:    f = FONT_3;
         4'd4:    f = FONT_4;
         4'd5:    f = FONT_5;
         4'd6:    f = FONT_6;
         4'd7:    f = FONT_7;
         4'd8:    f = FONT_8;
         4'd9:    f = FONT_9;
         default: f = FONT_BLANK;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// fnd_scan_ctrl_if: bundle between the timekeeping side and the scan controller.
//   digit_h, digit_l : 7-bit display values (0..99 valid), driven by master
//   dot              : dot request, driven by master
//   fnd_com          : active-low digit enables, driven by slave
//   fnd_font         : active-low segments {dp,g,f,e,d,c,b,a}, driven by slave
//   frame_tick       : one-cycle pulse per new snapshot, driven by slave
interface fnd_scan_ctrl_if;

   logic [6:0] digit_h;
   logic [6:0] digit_l;
   logic       dot;
   logic [3:0] fnd_com;
   logic [7:0] fnd_font;
   logic       frame_tick;

   modport master (
      output digit_h, digit_l, dot,
      input  fnd_com, fnd_font, frame_tick
   );

   modport slave (
      input  digit_h, digit_l, dot,
      output fnd_com, fnd_font, frame_tick
   );

endinterface

// File: rtl/fnd_bcd_font.sv
// fnd_bcd_font: splits a 7-bit value into tens/ones and returns both glyphs.
//   value     : input  7  value to render, 0..99 valid
//   tens_font : output 8  active-low glyph for the tens digit
//   ones_font : output 8  active-low glyph for the ones digit
// Values >= 100 render as two dashes rather than wrapping or truncating.
module fnd_bcd_font
   import fnd_pkg::*;
(
   input  logic [6:0] value,
   output logic [7:0] tens_font,
   output logic [7:0] ones_font
);

   logic [3:0] tens;
   logic [3:0] ones;

   always_comb begin
      tens      = 4'(value / 7'd10);
      ones      = 4'(value % 7'd10);
      tens_font = font_of(tens);
      ones_font = font_of(ones);
      if (value >= 7'd100) begin
         tens_font = FONT_DASH;
         ones_font = FONT_DASH;
      end
   end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan driver for a 4-digit common-anode display.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : fnd_scan_ctrl_if.slave (digit_h, digit_l, dot in; fnd_com,
//           fnd_font, frame_tick out)
// Each digit stays selected for DIV = SYS_HZ/SCAN_HZ clocks; inputs are
// snapshotted once per 4-digit frame so a frame never mixes values.
module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int unsigned SYS_HZ  = 100_000_000,
   parameter int unsigned SCAN_HZ = 1000
) (
   input  logic            clk,
   input  logic            reset,
   fnd_scan_ctrl_if.slave  bus
);

   localparam int unsigned DIV = SYS_HZ / SCAN_HZ;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] scan_cnt;
   logic          scan_tick;
   sel_e          sel;
   sel_e          sel_next;
   logic [6:0]    snap_h;
   logic [6:0]    snap_l;
   logic          snap_dot;
   logic [7:0]    h_tens;
   logic [7:0]    h_ones;
   logic [7:0]    l_tens;
   logic [7:0]    l_ones;
   logic [3:0]    com_next;
   logic [7:0]    font_next;
   logic          frame_end;

   assign scan_tick = (scan_cnt == CNT_LAST);
   assign frame_end = scan_tick && (sel == SEL_D3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         scan_cnt <= '0;
      else if (scan_tick) scan_cnt <= '0;
      else                scan_cnt <= scan_cnt + 1'b1;
   end

   // Digit select: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sel <= SEL_D0;
      else        sel <= sel_next;
   end

   // Digit select: next state
   always_comb begin
      sel_next = sel;
      if (scan_tick) begin
         case (sel)
            SEL_D0:  sel_next = SEL_D1;
            SEL_D1:  sel_next = SEL_D2;
            SEL_D2:  sel_next = SEL_D3;
            default: sel_next = SEL_D0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_h   <= '0;
         snap_l   <= '0;
         snap_dot <= 1'b0;
      end else if (frame_end) begin
         snap_h   <= bus.digit_h;
         snap_l   <= bus.digit_l;
         snap_dot <= bus.dot;
      end
   end

   fnd_bcd_font u_font_h (
      .value     (snap_h),
      .tens_font (h_tens),
      .ones_font (h_ones)
   );

   fnd_bcd_font u_font_l (
      .value     (snap_l),
      .tens_font (l_tens),
      .ones_font (l_ones)
   );

   // Digit select: outputs. The scan_tick cycle loads a blank so the old
   // glyph never appears on the newly enabled digit (ghosting guard).
   always_comb begin
      com_next  = COM_OFF;
      font_next = FONT_BLANK;
      case (sel)
         SEL_D0: begin com_next = COM_D0; font_next = l_ones; end
         SEL_D1: begin com_next = COM_D1; font_next = l_tens; end
         SEL_D2: begin
            com_next  = COM_D2;
            font_next = h_ones;
            if (snap_dot) font_next[DP_BIT] = 1'b0;
         end
         default: begin com_next = COM_D3; font_next = h_tens; end
      endcase
      if (scan_tick) begin
         com_next  = COM_OFF;
         font_next = FONT_BLANK;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.fnd_com    <= COM_OFF;
         bus.fnd_font   <= FONT_BLANK;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.fnd_com    <= com_next;
         bus.fnd_font   <= font_next;
         bus.frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: scoreboard bench for fnd_scan_ctrl with DIV = 10.
// A model process pushes the expected frame contents whenever a snapshot is
// due (every 40 clocks after reset release); a monitor pops on frame_tick and
// checks every displayed cycle against digit arithmetic on that frame.
module tb_fnd_scan_ctrl;

   localparam int unsigned DIV   = 10;
   localparam int unsigned FRAME = 4 * DIV;
   localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      int unsigned k;
      logic [6:0]  h;
      logic [6:0]  l;
      logic        d;
   } frame_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   fnd_scan_ctrl_if bus ();

   fnd_scan_ctrl #(.SYS_HZ(1000), .SCAN_HZ(100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   frame_t      q[$];
   frame_t      cur = '{0, 7'd0, 7'd0, 1'b0};
   int unsigned k = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_ticks = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", name, act, exp, k, $time);
      end
   endtask

   function automatic logic [7:0] exp_com(input int unsigned s);
      logic [3:0] c;
      c = 4'b1111;
      c[s] = 1'b0;
      return {4'h0, c};
   endfunction

   function automatic logic [7:0] exp_font(input int unsigned s, input frame_t f);
      int unsigned v;
      logic [7:0]  g;
      v = (s < 2) ? int'(f.l) : int'(f.h);
      if (v >= 100)        g = 8'hBF;
      else if (s % 2 == 0) g = GLYPH[v % 10];
      else                 g = GLYPH[v / 10];
      if (s == 2 && f.d) g[7] = 1'b0;
      return g;
   endfunction

   // Reference timeline: k counts clock edges since reset release; a snapshot
   // of whatever the inputs hold is due on every 40th edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         k = 0;
         q.delete();
      end else begin
         k = k + 1;
         if (k % FRAME == 0) q.push_back('{k, bus.digit_h, bus.digit_l, bus.dot});
      end
   end

   always @(negedge clk) begin
      int unsigned s;
      if (!reset) begin
         cur = '{0, 7'd0, 7'd0, 1'b0};
         check("rst_com", {4'h0, bus.fnd_com}, 8'h0F);
         check("rst_font", bus.fnd_font, 8'hFF);
         check("rst_tick", {7'd0, bus.frame_tick}, 8'd0);
      end else begin
         if (q.size() != 0 && q[0].k == k) begin
            check("tick_due", {7'd0, bus.frame_tick}, 8'd1);
            cur = q.pop_front();
         end else begin
            check("tick_idle", {7'd0, bus.frame_tick}, 8'd0);
         end
         if (bus.frame_tick) n_ticks++;
         s = (k / DIV) % 4;
         if (k % DIV == 0) begin
            check("blank_com", {4'h0, bus.fnd_com}, 8'h0F);
         end else begin
            check("com", {4'h0, bus.fnd_com}, exp_com(s));
            check("font", bus.fnd_font, exp_font(s, cur));
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic set_in(input int unsigned h, input int unsigned l, input bit d);
      bus.digit_h = 7'(h);
      bus.digit_l = 7'(l);
      bus.dot     = d;
   endtask

   // Advance until the model timeline is inside digit slot s (bounded).
   task automatic wait_slot(input int unsigned s, input int unsigned off);
      for (int i = 0; i < 2 * FRAME; i++) begin
         if ((k % FRAME) / DIV == s && (k % DIV) == off) return;
         wait_clk(1);
      end
      check("slot_timeout", 8'd0, 8'd1);
   endtask

   initial begin
      set_in(0, 0, 1'b0);
      wait_clk(5);
      reset = 1'b1;

      set_in(37, 5, 1'b1);
      wait_clk(2 * FRAME + 10);

      set_in(120, 99, 1'b0);
      wait_clk(FRAME);
      set_in(120, 99, 1'b1);
      wait_clk(FRAME + 5);

      set_in(40, 12, 1'b0);
      wait_slot(0, 3);
      wait_slot(1, 4);
      set_in(40, 34, 1'b0);
      wait_clk(2 * FRAME);

      for (int i = 0; i < 6; i++) begin
         set_in(88, 88, 1'(i % 2));
         wait_clk(FRAME);
      end

      for (int i = 0; i < 150; i++) begin
         set_in($urandom_range(0, 127), $urandom_range(0, 127), 1'($urandom_range(0, 1)));
         wait_clk($urandom_range(1, 30));
      end

      set_in(64, 21, 1'b1);
      wait_slot(2, 5);
      reset = 1'b0;
      #1;
      check("async_rst_com", {4'h0, bus.fnd_com}, 8'h0F);
      check("async_rst_font", bus.fnd_font, 8'hFF);
      check("async_rst_tick", {7'd0, bus.frame_tick}, 8'd0);
      wait_clk(3);
      reset = 1'b1;
      wait_clk(3 * FRAME);

      check("ticks_seen", {7'd0, n_ticks > 0}, 8'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
